// File: rtl/addsub_arbiter_if.sv
// Handshake bundle between two requesters, the add/sub arbiter and the result consumer.
interface addsub_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_dataa;
   logic [WIDTH-1:0] req0_datab;
   logic             req0_add_sub;
   logic             req0_ready;

   logic             req1_valid;
   logic [WIDTH-1:0] req1_dataa;
   logic [WIDTH-1:0] req1_datab;
   logic             req1_add_sub;
   logic             req1_ready;

   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_carry;
   logic             rsp_id;
   logic             rsp_ready;

   // Requester/consumer side
   modport master (
      output req0_valid, req0_dataa, req0_datab, req0_add_sub,
      input  req0_ready,
      output req1_valid, req1_dataa, req1_datab, req1_add_sub,
      input  req1_ready,
      input  rsp_valid, rsp_result, rsp_carry, rsp_id,
      output rsp_ready
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_dataa, req0_datab, req0_add_sub,
      output req0_ready,
      input  req1_valid, req1_dataa, req1_datab, req1_add_sub,
      output req1_ready,
      output rsp_valid, rsp_result, rsp_carry, rsp_id,
      input  rsp_ready
   );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared WIDTH-bit adder/subtractor.
// One operation issues per cycle into a one-entry result buffer that loads and
// drains in the same cycle, so full throughput is kept while rsp_ready is high.
module addsub_arbiter #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             reset,
   addsub_arbiter_if.slave bus
);

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   buf_state_t       state_r;
   logic             last_grant_r;
   logic [WIDTH-1:0] result_r;
   logic             carry_r;
   logic             id_r;

   logic             accept_s;
   logic             grant_valid_s;
   logic             grant_id_s;
   logic             handshake_s;
   logic [WIDTH-1:0] op_a_s;
   logic [WIDTH-1:0] op_b_s;
   logic             op_add_s;
   logic [WIDTH:0]   calc_s;

   // Returns {carry_or_borrow, result}; borrow is the inverted carry of a + ~b + 1.
   function automatic logic [WIDTH:0] addsub_f(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             add);
      logic [WIDTH:0] sum;
      if (add) begin
         sum = {1'b0, a} + {1'b0, b};
      end else begin
         sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
         sum[WIDTH] = ~sum[WIDTH];
      end
      return sum;
   endfunction

   // Buffer can take a new result when empty, or when full and draining this cycle.
   always_comb begin
      accept_s = 1'b0;
      case (state_r)
         BUF_EMPTY: accept_s = 1'b1;
         BUF_FULL:  accept_s = bus.rsp_ready;
         default:   accept_s = 1'b0;
      endcase
   end

   // Round-robin pick: under contention the requester not served last wins.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant_valid_s = 1'b1;
         grant_id_s    = ~last_grant_r;
      end else if (bus.req0_valid) begin
         grant_valid_s = 1'b1;
         grant_id_s    = 1'b0;
      end else if (bus.req1_valid) begin
         grant_valid_s = 1'b1;
         grant_id_s    = 1'b1;
      end else begin
         grant_valid_s = 1'b0;
         grant_id_s    = 1'b0;
      end
   end

   // Steer the granted requester's operands into the shared datapath.
   always_comb begin
      op_a_s   = {WIDTH{1'b0}};
      op_b_s   = {WIDTH{1'b0}};
      op_add_s = 1'b0;
      if (grant_id_s) begin
         op_a_s   = bus.req1_dataa;
         op_b_s   = bus.req1_datab;
         op_add_s = bus.req1_add_sub;
      end else begin
         op_a_s   = bus.req0_dataa;
         op_b_s   = bus.req0_datab;
         op_add_s = bus.req0_add_sub;
      end
   end

   // Readies are held low while reset is asserted so no transaction is lost into reset.
   assign handshake_s    = accept_s & grant_valid_s & ~reset;
   assign bus.req0_ready = handshake_s & ~grant_id_s;
   assign bus.req1_ready = handshake_s & grant_id_s;
   assign calc_s         = addsub_f(op_a_s, op_b_s, op_add_s);

   assign bus.rsp_valid  = (state_r == BUF_FULL);
   assign bus.rsp_result = result_r;
   assign bus.rsp_carry  = carry_r;
   assign bus.rsp_id     = id_r;

   // Result buffer state machine; last_grant moves only on an accepted transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= BUF_EMPTY;
         last_grant_r <= 1'b1;
         result_r     <= {WIDTH{1'b0}};
         carry_r      <= 1'b0;
         id_r         <= 1'b0;
      end else if (handshake_s) begin
         state_r      <= BUF_FULL;
         last_grant_r <= grant_id_s;
         result_r     <= calc_s[WIDTH-1:0];
         carry_r      <= calc_s[WIDTH];
         id_r         <= grant_id_s;
      end else if ((state_r == BUF_FULL) && bus.rsp_ready) begin
         state_r      <= BUF_EMPTY;
      end else begin
         state_r      <= state_r;
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vector table, hand-written
// reset/contention sequence, and randomized traffic against a behavioural model.
module tb_addsub_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   addsub_arbiter_if #(.WIDTH(8)) bus ();

   addsub_arbiter #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       v0;
      logic [7:0] a0;
      logic [7:0] b0;
      logic       op0;
      logic       v1;
      logic [7:0] a1;
      logic [7:0] b1;
      logic       op1;
      logic       rr;
      logic       e_r0;
      logic       e_r1;
      logic       e_valid;
      logic [7:0] e_res;
      logic       e_carry;
      logic       e_id;
   } vec_t;

   // Behavioural model state
   logic m_full;
   int   m_res;
   logic m_carry;
   logic m_id;
   logic m_last;
   logic m_exp_r0;
   logic m_exp_r1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full  = 1'b0;
      m_res   = 0;
      m_carry = 1'b0;
      m_id    = 1'b0;
      m_last  = 1'b1;
   endtask

   // One clock of the specification's rules with plain integer arithmetic.
   task automatic model_step(input vec_t v);
      logic can_take;
      logic who;
      logic any;
      int   a;
      int   b;
      logic add;
      can_take = !m_full || v.rr;
      any      = v.v0 || v.v1;
      if (v.v0 && v.v1) who = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else              who = v.v1;
      m_exp_r0 = can_take && any && (who == 1'b0);
      m_exp_r1 = can_take && any && (who == 1'b1);
      if (can_take && any) begin
         a   = who ? int'(v.a1) : int'(v.a0);
         b   = who ? int'(v.b1) : int'(v.b0);
         add = who ? v.op1 : v.op0;
         if (add) begin
            m_res   = (a + b) % 256;
            m_carry = (a + b) > 255;
         end else begin
            m_res   = (a - b + 256) % 256;
            m_carry = (a < b);
         end
         m_id   = who;
         m_last = who;
         m_full = 1'b1;
      end else if (m_full && v.rr) begin
         m_full = 1'b0;
      end
   endtask

   // Called at posedge+1: drive inputs, sample readies, advance model and clock.
   task automatic do_cycle(input vec_t v, output logic g0, output logic g1);
      bus.req0_valid   = v.v0;
      bus.req0_dataa   = v.a0;
      bus.req0_datab   = v.b0;
      bus.req0_add_sub = v.op0;
      bus.req1_valid   = v.v1;
      bus.req1_dataa   = v.a1;
      bus.req1_datab   = v.b1;
      bus.req1_add_sub = v.op1;
      bus.rsp_ready    = v.rr;
      #1;
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      model_step(v);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " valid"},  32'(bus.rsp_valid),  32'(m_full));
      chk({tag, " result"}, 32'(bus.rsp_result), m_res);
      chk({tag, " carry"},  32'(bus.rsp_carry),  32'(m_carry));
      chk({tag, " id"},     32'(bus.rsp_id),     32'(m_id));
   endtask

   function automatic vec_t mk(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                               input logic op0, input logic v1, input logic [7:0] a1,
                               input logic [7:0] b1, input logic op1, input logic rr,
                               input logic er0, input logic er1, input logic ev,
                               input logic [7:0] eres, input logic ec, input logic eid);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
      v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1;
      v.rr = rr; v.e_r0 = er0; v.e_r1 = er1; v.e_valid = ev;
      v.e_res = eres; v.e_carry = ec; v.e_id = eid;
      return v;
   endfunction

   vec_t tbl[15];
   vec_t cv;
   vec_t rv;
   logic g0;
   logic g1;
   logic p0;
   logic p1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        v0   a0     b0     op0   v1   a1     b1     op1   rr    r0    r1    val   res    c     id
      tbl[0]  = mk(1'b1, 8'h3C, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
      tbl[1]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hF0, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
      tbl[2]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1);
      tbl[3]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1);
      tbl[4]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1);
      tbl[5]  = mk(1'b1, 8'h01, 8'h02, 1'b1, 1'b1, 8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
      tbl[6]  = mk(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1);
      tbl[7]  = mk(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 8'h7F, 8'h7E, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
      tbl[9]  = mk(1'b1, 8'h7F, 8'h7E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      tbl[10] = mk(1'b1, 8'h7F, 8'h7E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      tbl[11] = mk(1'b1, 8'h7F, 8'h7E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
      tbl[12] = mk(1'b1, 8'h7F, 8'h7E, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      tbl[13] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      tbl[14] = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);

      // Reset with a requester already valid: nothing may be accepted.
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_dataa = 8'h00; bus.req0_datab = 8'h00; bus.req0_add_sub = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_dataa = 8'h00; bus.req1_datab = 8'h00; bus.req1_add_sub = 1'b0;
      bus.rsp_ready  = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid",  32'(bus.rsp_valid),  32'd0);
      chk("reset result", 32'(bus.rsp_result), 32'd0);
      chk("reset carry",  32'(bus.rsp_carry),  32'd0);
      chk("reset id",     32'(bus.rsp_id),     32'd0);
      chk("reset ready0", 32'(bus.req0_ready), 32'd0);
      reset = 1'b0;

      // Directed table: single add, wrap, borrow, idle no-rotate, contention, backpressure.
      for (int i = 0; i < 15; i++) begin
         do_cycle(tbl[i], g0, g1);
         chk($sformatf("vec%0d ready0", i), 32'(g0), 32'(tbl[i].e_r0));
         chk($sformatf("vec%0d ready1", i), 32'(g1), 32'(tbl[i].e_r1));
         chk($sformatf("vec%0d valid", i),  32'(bus.rsp_valid),  32'(tbl[i].e_valid));
         chk($sformatf("vec%0d result", i), 32'(bus.rsp_result), 32'(tbl[i].e_res));
         chk($sformatf("vec%0d carry", i),  32'(bus.rsp_carry),  32'(tbl[i].e_carry));
         chk($sformatf("vec%0d id", i),     32'(bus.rsp_id),     32'(tbl[i].e_id));
      end

      // Reset mid-stream: load a result, then reset drops rsp_valid before any edge.
      cv = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA0, 8'h0B, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b1);
      do_cycle(cv, g0, g1);
      chk("mid ready1", 32'(g1), 32'd1);
      chk("mid valid",  32'(bus.rsp_valid),  32'd1);
      chk("mid result", 32'(bus.rsp_result), 32'hAB);
      bus.req0_valid = 1'b1;
      reset = 1'b1;
      #1;
      chk("async valid drop", 32'(bus.rsp_valid),  32'd0);
      chk("async result",     32'(bus.rsp_result), 32'd0);
      chk("async ready0",     32'(bus.req0_ready), 32'd0);
      chk("async ready1",     32'(bus.req1_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Contention straight after reset: grants alternate 0,1,0,1.
      cv = mk(1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 8'h50, 8'h20, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_cycle(cv, g0, g1);
         chk($sformatf("cont%0d ready0", i), 32'(g0), 32'((i % 2) == 0));
         chk($sformatf("cont%0d ready1", i), 32'(g1), 32'((i % 2) == 1));
         chk($sformatf("cont%0d id", i),     32'(bus.rsp_id), 32'(i % 2));
         chk($sformatf("cont%0d result", i), 32'(bus.rsp_result),
             ((i % 2) == 0) ? 32'h33 : 32'h30);
      end

      // Randomized traffic against the model, honouring hold-until-ready.
      rv = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      p0 = 1'b0;
      p1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!p0) begin
            rv.v0  = ($urandom_range(0, 2) != 0);
            rv.a0  = 8'($urandom_range(0, 255));
            rv.b0  = 8'($urandom_range(0, 255));
            rv.op0 = 1'($urandom_range(0, 1));
         end
         if (!p1) begin
            rv.v1  = ($urandom_range(0, 2) != 0);
            rv.a1  = 8'($urandom_range(0, 255));
            rv.b1  = 8'($urandom_range(0, 255));
            rv.op1 = 1'($urandom_range(0, 1));
         end
         rv.rr = ($urandom_range(0, 3) != 0);
         do_cycle(rv, g0, g1);
         chk($sformatf("rand%0d ready0", i), 32'(g0), 32'(m_exp_r0));
         chk($sformatf("rand%0d ready1", i), 32'(g1), 32'(m_exp_r1));
         check_model($sformatf("rand%0d", i));
         p0 = rv.v0 && !g0;
         p1 = rv.v1 && !g1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester round-robin arbiter and sequencer for the shared WIDTH-bit adder/subtractor. It accepts operand/opcode transactions from two independent requesters over valid/ready handshakes and issues one operation per cycle to the single add/sub datapath. It returns each registered result tagged with the requester ID through a one-entry output buffer with backpressure. It sits between the lab control units and the arithmetic datapath, so two clients can share one adder without external muxing.

## Interface
- WIDTH, 8, operand and result width in bits
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a transaction
- req0_dataa  input  WIDTH  requester 0 operand A
- req0_datab  input  WIDTH  requester 0 operand B
- req0_add_sub  input  1  1 = add, 0 = subtract (A - B)
- req0_ready  output  1  requester 0 transaction accepted this cycle
- req1_valid, req1_dataa, req1_datab, req1_add_sub, req1_ready  same as requester 0, for requester 1
- rsp_valid  output  1  output buffer holds a result
- rsp_result  output  WIDTH  result, modulo 2^WIDTH
- rsp_carry  output  1  add: carry-out; subtract: borrow (1 when dataa < datab, unsigned)
- rsp_id  output  1  requester that issued the result
- rsp_ready  input  1  consumer accepts the result

## Operation
- Output buffer states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- accept = EMPTY or (FULL and rsp_ready). The buffer loads and drains in the same cycle, which gives full throughput.
- Arbitration: last_grant register (1 bit).
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- reqN_ready = accept and grant==N. This is combinational from valids and buffer state.
- Requesters must hold valid and operands stable until ready. Valid must not depend on ready.
- On handshake (reqN_valid and reqN_ready):
  - Compute a WIDTH+1-bit sum or difference of the granted operands.
  - Load rsp_result with the low WIDTH bits, rsp_carry with the carry or borrow bit, and rsp_id with N.
  - Set FULL and update last_grant to N.
- last_grant updates only on a handshake. An idle cycle does not rotate priority.
- FULL, rsp_ready=1, no valid requester: go to EMPTY. rsp_result, rsp_carry and rsp_id hold their last values.
- FULL, rsp_ready=0: hold all outputs and keep both reqN_ready low (backpressure).
- Arithmetic: unsigned wrap-around. Subtract borrow = NOT carry-out of A + ~B + 1.

## Timing
- Reset (async, immediate): rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_id=0, last_grant=1, so requester 0 wins the first contention.
- Latency: handshake in cycle T gives rsp_valid and data from the rising edge ending T, visible in cycle T+1.
- Throughput: one transaction per cycle while rsp_ready stays high.
- rsp_* change only on edges when a new result loads. They stay stable while rsp_valid=1 and rsp_ready=0.
- reqN_ready is low during reset and in the cycle after reset deassert if no valid is present.
- Reset mid-operation: the buffered result is discarded and rsp_valid drops asynchronously. The interrupted transaction is not reissued; the requester must re-present it.
- Consecutive contention alternates grants 0,1,0,1… Any requester waits at most one accepted transaction.

## Test plan
- Single add: req0 with A=8'h3C, B=8'h05, add → next cycle rsp_valid=1, result=8'h41, carry=0, id=0.
- Wrap and borrow, with rsp_ready=1 throughout:
  - req1 add A=8'hF0, B=8'h20 → result 8'h10, carry=1, id=1.
  - Then req1 subtract A=8'h05, B=8'h07 → result 8'hFE, carry(borrow)=1.
- Contention: both valid every cycle for 4 cycles after reset, rsp_ready=1 → grants 0,1,0,1. rsp_id sequence 0,1,0,1 one cycle later. Each ready pulses on alternate cycles.
- Backpressure:
  - A result is FULL and rsp_ready=0 for 3 cycles with req0 valid → req0_ready=0 and rsp_* held for all 3 cycles.
  - rsp_ready=1 → same-cycle req0 handshake, with the new result the following cycle.
- Reset mid-stream: assert reset while rsp_valid=1 → rsp_valid=0 immediately. After release with both valid, requester 0 is granted first.
- Idle no-rotate: req1 is served, then idle 2 cycles, then both valid → req0 is granted.
